// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage with PC register and 2-bit-counter BTB
//
// Purpose: owns the PC, drives the instruction-memory address and presents the
// fetched instruction, its PC and PC+1 to the IF/ID register. A direct-mapped
// BTB of 2-bit saturating counters predicts direction and target. Execute-stage
// branch resolutions train the BTB, and a mispredict redirect restarts fetch
// while flushF tells IF/ID to discard the wrong-path instruction.
//
// Ports:
//   clk, reset                      clock (rising edge), async active-high reset
//   stall                           hold the PC
//   imem_addr / imem_rdata          combinational instruction-memory read
//   instructionFetch, pcF, pcPlus1F fetched instruction, its PC, PC+1 (wrapping)
//   predTakenF, predTargetF         BTB prediction for pcF
//   resolve_valid/pc/taken/target   branch outcome from execute, trains the BTB
//   redirect_valid, redirect_pc     mispredict restart (beats stall)
//   flushF                          IF/ID flush, equal to redirect_valid

module fetch_unit #(
    parameter int              PC_W     = 6,
    parameter int              INSTR_W  = 32,
    parameter int              IDX_W    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instructionFetch,
    output logic [PC_W-1:0]    pcF,
    output logic [PC_W-1:0]    pcPlus1F,
    output logic               predTakenF,
    output logic [PC_W-1:0]    predTargetF,
    input  logic               resolve_valid,
    input  logic [PC_W-1:0]    resolve_pc,
    input  logic               resolve_taken,
    input  logic [PC_W-1:0]    resolve_target,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               flushF
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = PC_W - IDX_W;

    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pc_next;

    logic             btb_valid  [ENTRIES];
    logic [TAG_W-1:0] btb_tag    [ENTRIES];
    logic [PC_W-1:0]  btb_target [ENTRIES];
    logic [1:0]       btb_ctr    [ENTRIES];

    logic [IDX_W-1:0] look_idx;
    logic [TAG_W-1:0] look_tag;
    logic             look_hit;

    logic [IDX_W-1:0] res_idx;
    logic [TAG_W-1:0] res_tag;
    logic             res_hit;

    // Lookup for the PC being fetched; reads the array before any update
    // landing on the same edge, so a same-index resolve is seen next cycle.
    assign look_idx = pc[IDX_W-1:0];
    assign look_tag = pc[PC_W-1:IDX_W];
    assign look_hit = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);

    assign res_idx  = resolve_pc[IDX_W-1:0];
    assign res_tag  = resolve_pc[PC_W-1:IDX_W];
    assign res_hit  = btb_valid[res_idx] && (btb_tag[res_idx] == res_tag);

    assign imem_addr        = pc;
    assign pcF              = pc;
    assign pcPlus1F         = pc + PC_W'(1);
    assign instructionFetch = imem_rdata;
    assign predTakenF       = look_hit && btb_ctr[look_idx][1];
    assign predTargetF      = btb_target[look_idx];
    assign flushF           = redirect_valid;

    // Redirect wins over stall: the wrong-path instruction held by a stall is
    // exactly what the flush discards.
    always_comb begin
        pc_next = pcPlus1F;
        if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (stall) begin
            pc_next = pc;
        end else if (predTakenF) begin
            pc_next = predTargetF;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    // BTB training runs regardless of stall/redirect: the resolution comes
    // from execute and is valid whatever fetch is doing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_ctr[i]    <= 2'b01;
            end
        end else if (resolve_valid) begin
            if (res_hit) begin
                if (resolve_taken) begin
                    if (btb_ctr[res_idx] != 2'b11) begin
                        btb_ctr[res_idx] <= btb_ctr[res_idx] + 2'b01;
                    end
                    btb_target[res_idx] <= resolve_target;
                end else if (btb_ctr[res_idx] != 2'b00) begin
                    btb_ctr[res_idx] <= btb_ctr[res_idx] - 2'b01;
                end
            end else if (resolve_taken) begin
                // New entries start weakly taken so the next visit predicts taken.
                btb_valid[res_idx]  <= 1'b1;
                btb_tag[res_idx]    <= res_tag;
                btb_target[res_idx] <= resolve_target;
                btb_ctr[res_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit

module tb_fetch_unit;

    localparam int PC_W    = 6;
    localparam int INSTR_W = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic               stall;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instructionFetch;
    logic [PC_W-1:0]    pcF;
    logic [PC_W-1:0]    pcPlus1F;
    logic               predTakenF;
    logic [PC_W-1:0]    predTargetF;
    logic               resolve_valid;
    logic [PC_W-1:0]    resolve_pc;
    logic               resolve_taken;
    logic [PC_W-1:0]    resolve_target;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               flushF;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    // Instruction memory model: distinctive word derived from the address.
    assign imem_rdata = 32'hA5A5_0000 | 32'(imem_addr);

    fetch_unit #(.PC_W(6), .INSTR_W(32), .IDX_W(4), .RESET_PC(6'd0)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .instructionFetch (instructionFetch),
        .pcF              (pcF),
        .pcPlus1F         (pcPlus1F),
        .predTakenF       (predTakenF),
        .predTargetF      (predTargetF),
        .resolve_valid    (resolve_valid),
        .resolve_pc       (resolve_pc),
        .resolve_taken    (resolve_taken),
        .resolve_target   (resolve_target),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flushF           (flushF)
    );

    task automatic push(input string tag, input logic [31:0] val);
        sb.push_back('{tag, val});
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed %0h expected <none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Expected fetch bundle for a PC: address, pcF, pcPlus1F (wrapping), instruction.
    task automatic expect_fetch(input string tag, input int pc);
        logic [PC_W-1:0] p;
        logic [PC_W-1:0] p1;
        p  = PC_W'(pc);
        p1 = PC_W'(pc + 1);
        push({tag, "_addr"}, 32'(p));
        push({tag, "_pc"},   32'(p));
        push({tag, "_pc1"},  32'(p1));
        push({tag, "_ins"},  32'hA5A5_0000 | 32'(p));
    endtask

    task automatic check_fetch(input string tag, input int pc);
        expect_fetch(tag, pc);
        pop_cmp(32'(imem_addr));
        pop_cmp(32'(pcF));
        pop_cmp(32'(pcPlus1F));
        pop_cmp(instructionFetch);
    endtask

    task automatic check_pred(input string tag, input logic taken, input int target);
        push({tag, "_taken"}, 32'(taken));
        pop_cmp(32'(predTakenF));
        if (taken) begin
            push({tag, "_tgt"}, 32'(target));
            pop_cmp(32'(predTargetF));
        end
    endtask

    task automatic check_flush(input string tag, input logic f);
        push(tag, 32'(f));
        pop_cmp(32'(flushF));
    endtask

    // Advance one clock; inputs change and outputs settle 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input int pc);
        redirect_valid = 1'b1;
        redirect_pc    = PC_W'(pc);
        step();
        redirect_valid = 1'b0;
        #1;
    endtask

    task automatic resolve(input int pc, input logic taken, input int target);
        resolve_valid  = 1'b1;
        resolve_pc     = PC_W'(pc);
        resolve_taken  = taken;
        resolve_target = PC_W'(target);
    endtask

    initial begin
        reset          = 1'b1;
        stall          = 1'b0;
        resolve_valid  = 1'b0;
        resolve_pc     = '0;
        resolve_taken  = 1'b0;
        resolve_target = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset state
        #2;
        check_fetch("rst", 0);
        check_pred("rst", 1'b0, 0);
        check_flush("rst_flush", 1'b0);
        #10;
        reset = 1'b0;
        #1;

        // Test 1: sequential fetch from reset with an empty BTB
        for (int i = 0; i < 5; i++) begin
            check_fetch("t1", i);
            check_pred("t1", 1'b0, 0);
            step();
        end
        check_fetch("t1_end", 5);

        // Test 2: PC wrap at 63
        redirect_valid = 1'b1;
        redirect_pc    = 6'd63;
        #1;
        check_flush("t2_flush", 1'b1);
        step();
        redirect_valid = 1'b0;
        #1;
        check_flush("t2_noflush", 1'b0);
        check_fetch("t2_63", 63);
        check_pred("t2_63", 1'b0, 0);
        step();
        check_fetch("t2_wrap", 0);

        // Test 3: stall holds the PC
        redirect_to(7);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_fetch("t3_hold", 7);
            step();
        end
        check_fetch("t3_hold_end", 7);
        stall = 1'b0;
        step();
        check_fetch("t3_release", 8);

        // Test 4: allocate on taken resolve, then predict
        resolve(5, 1'b1, 20);
        step();
        resolve_valid = 1'b0;
        redirect_to(5);
        check_fetch("t4_at5", 5);
        check_pred("t4_at5", 1'b1, 20);
        step();
        check_fetch("t4_tgt", 20);
        step();
        // Test 6a: pc 21 shares index 5 but has tag 1
        check_fetch("t6_at21", 21);
        check_pred("t6_tagmiss", 1'b0, 0);
        step();
        check_fetch("t6_22", 22);

        // Not-taken resolve in the same cycle as a lookup of pc 5:
        // lookup still sees the old (weakly taken) counter.
        redirect_to(5);
        resolve(5, 1'b0, 0);
        #1;
        check_pred("t4_same_cycle", 1'b1, 20);
        step();
        check_fetch("t4_same_tgt", 20);
        resolve(5, 1'b0, 0);
        step();
        resolve_valid = 1'b0;
        redirect_to(5);
        check_pred("t4_weak", 1'b0, 0);
        step();
        check_fetch("t4_fall", 6);

        // Retrain back to taken (00 -> 01 -> 10)
        resolve(5, 1'b1, 20);
        step();
        step();
        resolve_valid = 1'b0;
        redirect_to(5);
        check_pred("t4_retrain", 1'b1, 20);

        // Test 5: redirect beats stall, flush is same-cycle
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 6'd33;
        #1;
        check_flush("t5_flush", 1'b1);
        step();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        #1;
        check_fetch("t5_33", 33);

        // Test 6b: async reset mid-cycle clears PC and BTB
        step();
        #2;
        reset = 1'b1;
        #1;
        check_fetch("t6_rst", 0);
        #1;
        reset = 1'b0;
        redirect_to(5);
        check_pred("t6_cleared", 1'b0, 0);
        step();
        check_fetch("t6_after", 6);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_leftover observed %0d expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
